// File: rtl/conv_win_fetch.sv
// conv_win_fetch: reads a raster image from the source RAM, keeps the two previous
// rows in line buffers and streams every valid 3x3 window over a valid/ready port.
module conv_win_fetch #(
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 12,
  parameter int unsigned RD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            cena,
  output logic [AW-1:0]   aa,
  input  logic [DW-1:0]   qa,
  output logic            win_valid,
  input  logic            win_ready,
  output logic [9*DW-1:0] win_data,
  output logic [4:0]      win_row,
  output logic [4:0]      win_col,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  localparam logic [AW-1:0] LastAddr   = AW'(IMG_W * IMG_H - 1);
  localparam logic [4:0]    LastCol    = 5'(IMG_W - 1);
  localparam logic [4:0]    LastWinRow = 5'(IMG_H - 3);
  localparam logic [4:0]    LastWinCol = 5'(IMG_W - 3);

  state_e state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [RD_LAT-1:0] inflt_q, inflt_d;
  logic [1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [4:0]        px_col_q, px_col_d, px_row_q, px_row_d;
  logic              win_valid_q, win_valid_d;
  logic [9*DW-1:0]   win_data_q, win_data_d;
  logic [4:0]        win_row_q, win_row_d, win_col_q, win_col_d;

  logic [DW-1:0] fifo_q [4];
  logic [DW-1:0] lb0_q [IMG_W];
  logic [DW-1:0] lb1_q [IMG_W];
  logic [DW-1:0] w_q [3][3];
  logic [DW-1:0] col_new [3];

  logic [3:0]    inflt_cnt;
  logic          issue, push, pop, emit, emit_pos, accept;
  logic [DW-1:0] pop_px;

  // Credit check, FIFO pop gating and the incoming window column.
  always_comb begin
    inflt_cnt = '0;
    for (int i = 0; i < int'(RD_LAT); i++) inflt_cnt = inflt_cnt + 4'(inflt_q[i]);
    issue    = (state_q == StFetch) && ((inflt_cnt + {1'b0, cnt_q}) < 4'd4);
    push     = inflt_q[RD_LAT-1];
    accept   = win_valid_q & win_ready;
    emit_pos = (px_row_q >= 5'd2) && (px_col_q >= 5'd2);
    // Buffer-only pops never wait on the consumer.
    pop      = (cnt_q != 3'd0) && (!emit_pos || !win_valid_q || win_ready);
    emit     = pop && emit_pos;
    pop_px   = fifo_q[rd_ptr_q];
    col_new[0] = lb0_q[px_col_q];
    col_new[1] = lb1_q[px_col_q];
    col_new[2] = pop_px;
  end

  // Next-state for FSM, read address, in-flight tracker, FIFO and counters.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    px_col_d = px_col_q;
    px_row_d = px_row_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: if (issue && (addr_q == LastAddr)) state_d = StDrain;
      StDrain: if (accept && (win_row_q == LastWinRow) && (win_col_q == LastWinCol))
                 state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (issue) addr_d = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
    inflt_d  = (inflt_q << 1) | RD_LAT'(issue);
    wr_ptr_d = wr_ptr_q + 2'(push);
    rd_ptr_d = rd_ptr_q + 2'(pop);
    cnt_d    = cnt_q + 3'(push) - 3'(pop);
    if (state_q == StIdle) begin
      px_col_d = '0;
      px_row_d = '0;
    end else if (pop) begin
      if (px_col_q == LastCol) begin
        px_col_d = '0;
        px_row_d = px_row_q + 5'd1;
      end else begin
        px_col_d = px_col_q + 5'd1;
      end
    end
  end

  // Output slot: reload on emit (even while accepting), clear on accept alone.
  always_comb begin
    win_valid_d = win_valid_q;
    win_data_d  = win_data_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    if (emit) begin
      win_valid_d = 1'b1;
      win_row_d   = px_row_q - 5'd2;
      win_col_d   = px_col_q - 5'd2;
      for (int r = 0; r < 3; r++) begin
        win_data_d[(3*r+0)*DW +: DW] = w_q[r][1];
        win_data_d[(3*r+1)*DW +: DW] = w_q[r][2];
        win_data_d[(3*r+2)*DW +: DW] = col_new[r];
      end
    end else if (accept) begin
      win_valid_d = 1'b0;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      inflt_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      px_col_q    <= '0;
      px_row_q    <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      inflt_q     <= inflt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      px_col_q    <= px_col_d;
      px_row_q    <= px_row_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

  // Pixel storage: FIFO, line buffers and the 3x3 shift window (no reset needed).
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= qa;
    if (pop) begin
      lb0_q[px_col_q] <= lb1_q[px_col_q];
      lb1_q[px_col_q] <= pop_px;
      for (int r = 0; r < 3; r++) begin
        w_q[r][0] <= w_q[r][1];
        w_q[r][1] <= w_q[r][2];
        w_q[r][2] <= col_new[r];
      end
    end
  end

  assign cena      = ~issue;
  assign aa        = addr_q;
  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_conv_win_fetch.sv
// Directed bench for conv_win_fetch with a RAM model and a window scoreboard.
module tb_conv_win_fetch;
  localparam int unsigned W = 28, H = 28, DW = 8, AW = 12, RD_LAT = 2;
  localparam int NWIN = (W - 2) * (H - 2);
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic rst, start, cena, win_valid, win_ready, busy, done;
  logic [AW-1:0] aa;
  logic [DW-1:0] qa;
  logic [9*DW-1:0] win_data;
  logic [4:0] win_row, win_col;

  conv_win_fetch #(.IMG_W(W), .IMG_H(H), .DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .cena(cena), .aa(aa), .qa(qa),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // RAM model: RD_LAT-stage read pipeline.
  logic [DW-1:0] mem [NPIX];
  logic [DW-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (!cena) rd_pipe[0] <= mem[aa];
    for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign qa = rd_pipe[RD_LAT-1];

  typedef struct {
    logic [4:0]  r;
    logic [4:0]  c;
    logic [71:0] d;
  } win_t;
  win_t sb[$];

  int n_cmp = 0, n_err = 0;
  int acc_cnt, rd_cnt, done_cnt;
  int exp_addr;
  logic mon_en;
  logic done_exp, prev_stall;
  logic [71:0] prev_data;
  logic [4:0] prev_row, prev_col;
  win_t e;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] d;
    d = '0;
    for (int tr = 0; tr < 3; tr++)
      for (int tc = 0; tc < 3; tc++)
        d[(3*tr+tc)*8 +: 8] = 8'(((r + tr) * W + c + tc) % 256);
    return d;
  endfunction

  // Output, done and read-port monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!mon_en) begin
      done_exp   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("done_pulse", {71'd0, done}, {71'd0, done_exp});
      done_exp = 1'b0;
      if (done) done_cnt++;
      if (prev_stall) begin
        chk("stall_valid", {71'd0, win_valid}, 72'd1);
        chk("stall_data", win_data, prev_data);
        chk("stall_row", {67'd0, win_row}, {67'd0, prev_row});
        chk("stall_col", {67'd0, win_col}, {67'd0, prev_col});
      end
      prev_stall = win_valid && !win_ready;
      prev_data  = win_data;
      prev_row   = win_row;
      prev_col   = win_col;
      if (win_valid && win_ready) begin
        acc_cnt++;
        if (sb.size() == 0) begin
          chk("extra_window", 72'd1, 72'd0);
        end else begin
          e = sb.pop_front();
          chk("win_row", {67'd0, win_row}, {67'd0, e.r});
          chk("win_col", {67'd0, win_col}, {67'd0, e.c});
          chk("win_data", win_data, e.d);
          done_exp = (e.r == 5'(H - 3)) && (e.c == 5'(W - 3));
        end
      end
      if (!cena) begin
        chk("rd_addr", {60'd0, aa}, 72'(exp_addr));
        exp_addr++;
        rd_cnt++;
      end
    end
  end

  task automatic begin_pass();
    win_t w;
    exp_addr = 0;
    rd_cnt   = 0;
    acc_cnt  = 0;
    for (int r = 0; r < H - 2; r++)
      for (int c = 0; c < W - 2; c++) begin
        w.r = 5'(r);
        w.c = 5'(c);
        w.d = exp_win(r, c);
        sb.push_back(w);
      end
    @(posedge clk); #1 start = 1'b1;
    chk("cena_idle_at_start", {71'd0, cena}, 72'd1);
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_acc(input int n);
    int k;
    k = 0;
    while (acc_cnt < n && k < 5000) begin
      @(posedge clk);
      k++;
    end
    chk("wait_acc_timeout", 72'(k < 5000), 72'd1);
  endtask

  task automatic finish_pass(input bit rand_ready);
    int k, d0;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < 20000) begin
      @(posedge clk);
      #1;
      if (rand_ready) win_ready = 1'($urandom_range(0, 1));
      k++;
    end
    chk("done_timeout", 72'(k < 20000), 72'd1);
    win_ready = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_done", {71'd0, busy}, 72'd0);
    chk("done_count", 72'(done_cnt - d0), 72'd1);
    chk("read_count", 72'(rd_cnt), 72'(NPIX));
    chk("window_count", 72'(acc_cnt), 72'(NWIN));
    chk("scoreboard_empty", 72'(sb.size()), 72'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cena"}, {71'd0, cena}, 72'd1);
    chk({tag, "_aa"}, {60'd0, aa}, 72'd0);
    chk({tag, "_valid"}, {71'd0, win_valid}, 72'd0);
    chk({tag, "_data"}, win_data, 72'd0);
    chk({tag, "_row"}, {67'd0, win_row}, 72'd0);
    chk({tag, "_col"}, {67'd0, win_col}, 72'd0);
    chk({tag, "_busy"}, {71'd0, busy}, 72'd0);
    chk({tag, "_done"}, {71'd0, done}, 72'd0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i % 256);
    rst = 1'b1; start = 1'b0; win_ready = 1'b1; mon_en = 1'b0;
    acc_cnt = 0; rd_cnt = 0; done_cnt = 0; exp_addr = 0;
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    // T1/T2/T3: full pass, consumer always ready.
    begin_pass();
    finish_pass(1'b0);

    // T4: long stall mid-row, then random backpressure.
    begin_pass();
    wait_acc(40);
    #1 win_ready = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("cena_credit_exhausted", {71'd0, cena}, 72'd1);
    chk("valid_held", {71'd0, win_valid}, 72'd1);
    finish_pass(1'b1);

    // T5: start pulses while busy are ignored.
    begin_pass();
    wait_acc(100);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_acc(300);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    finish_pass(1'b0);

    // T6: reset mid-image at aa=300, then a clean pass.
    begin_pass();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(!cena && aa == 12'd300) && k < 5000);
    chk("reach_aa300", 72'(k < 5000), 72'd1);
    mon_en = 1'b0;
    #1 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    mon_en = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk("no_output_after_rst", {71'd0, win_valid}, 72'd0);
    begin_pass();
    finish_pass(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
